logger_record_packer: RTL and testbench

- Upstream neighbour of the logger byte FIFO.
- Takes one-cycle timestamp event records from the capture logic and serialises each into a fixed 13-byte framed packet.
- Writes the packet into the FIFO write port, one byte per cycle.
- Admission is gated on the FIFO's prog_full so a whole frame always fits; records that cannot be admitted are dropped and counted, never partially written.

---
 rtl/logger_record_packer.sv | 109 ++++++++++
 tb/tb_logger_record_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logger_record_packer.sv
// Serialises one-cycle timestamp event records into 13-byte framed packets
// (sync, event, seq, ts, checksum) and writes them to the logger byte FIFO.
module logger_record_packer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rec_valid,
   input  logic [7:0]       rec_event,
   input  logic [15:0]      rec_seq,
   input  logic [63:0]      rec_ts,
   output logic             rec_ready,
   output logic             fifo_wr_en,
   output logic [7:0]       fifo_din,
   input  logic             fifo_full,
   input  logic             fifo_prog_full,
   output logic             busy,
   output logic [CNT_W-1:0] drop_count
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   localparam logic [3:0] LAST_IDX = 4'd12;

   logic [0:0]  state;
   logic [3:0]  idx;
   logic [7:0]  cap_event;
   logic [15:0] cap_seq;
   logic [63:0] cap_ts;
   logic [7:0]  cap_csum;
   logic [7:0]  csum_in;
   logic        accept;
   logic        drop;

   // Outputs are forced quiet while rst is high so a reset aborts a frame at once.
   always_comb begin
      rec_ready  = !rst && (state == IDLE) && !fifo_prog_full;
      busy       = !rst && (state == EMIT);
      fifo_wr_en = busy && !fifo_full;
      accept     = rec_valid && rec_ready;
      drop       = rec_valid && !rec_ready;
   end

   // Checksum covers bytes 0..11 and is taken from the inputs at accept time.
   always_comb begin
      csum_in = SYNC_BYTE ^ rec_event ^ rec_seq[15:8] ^ rec_seq[7:0];
      for (int unsigned i = 0; i < 8; i++) begin
         csum_in = csum_in ^ rec_ts[i*8 +: 8];
      end
   end

   always_comb begin
      fifo_din = '0;
      if (state == EMIT) begin
         case (idx)
            4'd0:    fifo_din = SYNC_BYTE;
            4'd1:    fifo_din = cap_event;
            4'd2:    fifo_din = cap_seq[15:8];
            4'd3:    fifo_din = cap_seq[7:0];
            4'd4:    fifo_din = cap_ts[63:56];
            4'd5:    fifo_din = cap_ts[55:48];
            4'd6:    fifo_din = cap_ts[47:40];
            4'd7:    fifo_din = cap_ts[39:32];
            4'd8:    fifo_din = cap_ts[31:24];
            4'd9:    fifo_din = cap_ts[23:16];
            4'd10:   fifo_din = cap_ts[15:8];
            4'd11:   fifo_din = cap_ts[7:0];
            4'd12:   fifo_din = cap_csum;
            default: fifo_din = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         cap_event <= '0;
         cap_seq   <= '0;
         cap_ts    <= '0;
         cap_csum  <= '0;
      end else if (accept) begin
         state     <= EMIT;
         idx       <= '0;
         cap_event <= rec_event;
         cap_seq   <= rec_seq;
         cap_ts    <= rec_ts;
         cap_csum  <= csum_in;
      end else if (fifo_wr_en) begin
         if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
         end else begin
            idx <= idx + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_logger_record_packer.sv
// Bench for logger_record_packer: table-driven frames, stall, drop, reset and
// prog_full corner cases, with a byte scoreboard on the FIFO write port.
module tb_logger_record_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rec_valid;
   logic [7:0]  rec_event;
   logic [15:0] rec_seq;
   logic [63:0] rec_ts;
   logic        rec_ready;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic        fifo_full;
   logic        fifo_prog_full;
   logic        busy;
   logic [15:0] drop_count;

   logic        rec_valid_s;
   logic        rec_ready_s;
   logic        fifo_wr_en_s;
   logic [7:0]  fifo_din_s;
   logic        fifo_full_s;
   logic        fifo_prog_full_s;
   logic        busy_s;
   logic [3:0]  drop_count_s;

   always #5 clk = ~clk;

   logger_record_packer #(.SYNC_BYTE(8'hA5), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_event(rec_event),
      .rec_seq(rec_seq), .rec_ts(rec_ts), .rec_ready(rec_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .fifo_prog_full(fifo_prog_full), .busy(busy), .drop_count(drop_count)
   );

   logger_record_packer #(.SYNC_BYTE(8'hA5), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .rec_valid(rec_valid_s), .rec_event(rec_event),
      .rec_seq(rec_seq), .rec_ts(rec_ts), .rec_ready(rec_ready_s),
      .fifo_wr_en(fifo_wr_en_s), .fifo_din(fifo_din_s), .fifo_full(fifo_full_s),
      .fifo_prog_full(fifo_prog_full_s), .busy(busy_s), .drop_count(drop_count_s)
   );

   typedef struct {
      logic [7:0]  ev;
      logic [15:0] seq;
      logic [63:0] ts;
      logic [7:0]  exp_csum;
      int          exp_busy;
   } vec_t;

   vec_t       tv[5];
   logic [7:0] sb_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         wr_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_byte(input vec_t v, input int idx);
      case (idx)
         0:       return 8'hA5;
         1:       return v.ev;
         2:       return v.seq[15:8];
         3:       return v.seq[7:0];
         12:      return v.exp_csum;
         default: return v.ts[(11-idx)*8 +: 8];
      endcase
   endfunction

   // Every FIFO write is matched against the next expected byte.
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wr_count++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none", fifo_din);
         end else begin
            chk("frame_byte", {56'd0, fifo_din}, {56'd0, sb_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v, input logic exp_ready);
      rec_event = v.ev;
      rec_seq   = v.seq;
      rec_ts    = v.ts;
      rec_valid = 1'b1;
      @(negedge clk);
      chk("rec_ready_at_send", {63'd0, rec_ready}, {63'd0, exp_ready});
      if (exp_ready) begin
         for (int i = 0; i < 13; i++) sb_q.push_back(frame_byte(v, i));
      end
      tick();
      rec_valid = 1'b0;
   endtask

   // Starts in the cycle after accept (c=0 presents byte 0); returns at the
   // negedge of the first idle cycle.
   task automatic run_frame(input int stall_at, input int stall_len, input logic [7:0] held,
                            input logic [63:0] pulse_mask, output int nbusy);
      nbusy = 0;
      for (int c = 0; c < 60; c++) begin
         fifo_full = (c >= stall_at) && (c < stall_at + stall_len);
         rec_valid = pulse_mask[c];
         rec_event = 8'hEE;
         rec_seq   = 16'hBEEF;
         rec_ts    = 64'hDEAD_BEEF_CAFE_F00D;
         @(negedge clk);
         if (!busy) break;
         nbusy++;
         chk("rec_ready_while_busy", {63'd0, rec_ready}, 64'd0);
         if (fifo_full) begin
            chk("stall_wr_en", {63'd0, fifo_wr_en}, 64'd0);
            chk("stall_din_held", {56'd0, fifo_din}, {56'd0, held});
         end
         tick();
      end
      rec_valid = 1'b0;
      fifo_full = 1'b0;
   endtask

   task automatic frame_end_checks(input string tag, input int nbusy, input int exp_busy,
                                   input int writes);
      chk({tag, "_busy_cycles"}, nbusy, exp_busy);
      chk({tag, "_writes"}, writes, 13);
      chk({tag, "_ready_after"}, {63'd0, rec_ready}, 64'd1);
      chk({tag, "_idle_din"}, {56'd0, fifo_din}, 64'd0);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      int w0;

      tv[0] = '{8'h01, 16'h0002, 64'h0000_0000_0000_0003, 8'hA5, 13};
      tv[1] = '{8'hFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5A, 13};
      tv[2] = '{8'h00, 16'h0000, 64'h0000_0000_0000_0000, 8'hA5, 13};
      tv[3] = '{8'h5A, 16'h1234, 64'h0123_4567_89AB_CDEF, 8'hD9, 13};
      tv[4] = '{8'h80, 16'h8001, 64'h8000_0000_0000_0001, 8'h25, 13};

      rst = 1'b1; rec_valid = 1'b0; rec_event = '0; rec_seq = '0; rec_ts = '0;
      fifo_full = 1'b0; fifo_prog_full = 1'b0;
      rec_valid_s = 1'b0; fifo_full_s = 1'b0; fifo_prog_full_s = 1'b1;

      repeat (3) tick();
      @(negedge clk);
      chk("in_reset_wr_en", {63'd0, fifo_wr_en}, 64'd0);
      chk("in_reset_busy", {63'd0, busy}, 64'd0);
      chk("in_reset_ready", {63'd0, rec_ready}, 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {63'd0, rec_ready}, 64'd1);
      chk("post_reset_busy", {63'd0, busy}, 64'd0);
      chk("post_reset_wr_en", {63'd0, fifo_wr_en}, 64'd0);
      chk("post_reset_drops", {48'd0, drop_count}, 64'd0);
      tick();

      for (int i = 0; i < 5; i++) begin
         w0 = wr_count;
         send(tv[i], 1'b1);
         run_frame(99, 0, 8'h00, 64'd0, nb);
         frame_end_checks("table", nb, tv[i].exp_busy, wr_count - w0);
         tick();
      end

      // fifo_full for 3 cycles while byte 5 (ts[55:48]=23) is presented
      w0 = wr_count;
      send(tv[3], 1'b1);
      run_frame(5, 3, 8'h23, 64'd0, nb);
      frame_end_checks("stall", nb, 16, wr_count - w0);
      tick();

      // Pulses 1 and 5 cycles after accept are dropped; frame stays intact
      w0 = wr_count;
      send(tv[0], 1'b1);
      run_frame(99, 0, 8'h00, 64'h11, nb);
      frame_end_checks("drop", nb, 13, wr_count - w0);
      chk("drop_count_busy", {48'd0, drop_count}, 64'd2);
      tick();

      // Reset while byte index 7 is presented
      w0 = wr_count;
      send(tv[3], 1'b1);
      repeat (7) tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_wr_en", {63'd0, fifo_wr_en}, 64'd0);
      chk("rst_mid_ready", {63'd0, rec_ready}, 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
      chk("after_rst_busy", {63'd0, busy}, 64'd0);
      chk("after_rst_drops", {48'd0, drop_count}, 64'd0);
      chk("after_rst_partial_writes", wr_count - w0, 7);
      sb_q.delete();
      tick();
      w0 = wr_count;
      send(tv[0], 1'b1);
      run_frame(99, 0, 8'h00, 64'd0, nb);
      frame_end_checks("after_rst", nb, 13, wr_count - w0);
      tick();

      // prog_full in IDLE: everything dropped, no writes
      fifo_prog_full = 1'b1;
      w0 = wr_count;
      @(negedge clk);
      chk("prog_full_ready", {63'd0, rec_ready}, 64'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         rec_event = 8'h10 + 8'(i);
         rec_valid = 1'b1;
         tick();
         rec_valid = 1'b0;
         tick();
      end
      @(negedge clk);
      chk("prog_full_drops", {48'd0, drop_count}, 64'd4);
      chk("prog_full_writes", wr_count - w0, 0);
      chk("prog_full_busy", {63'd0, busy}, 64'd0);
      tick();
      fifo_prog_full = 1'b0;
      w0 = wr_count;
      send(tv[1], 1'b1);
      run_frame(99, 0, 8'h00, 64'd0, nb);
      frame_end_checks("after_prog_full", nb, 13, wr_count - w0);
      chk("after_prog_full_drops", {48'd0, drop_count}, 64'd4);
      tick();

      // 4-bit counter saturates at F
      rec_valid_s = 1'b1;
      repeat (14) tick();
      @(negedge clk);
      chk("sat_count_14", {60'd0, drop_count_s}, 64'hE);
      tick();
      repeat (5) tick();
      rec_valid_s = 1'b0;
      @(negedge clk);
      chk("sat_count_20", {60'd0, drop_count_s}, 64'hF);
      chk("sat_ready", {63'd0, rec_ready_s}, 64'd0);
      chk("sat_wr_en", {63'd0, fifo_wr_en_s}, 64'd0);
      chk("sat_busy", {63'd0, busy_s}, 64'd0);
      chk("sat_din", {56'd0, fifo_din_s}, 64'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
